// File: rtl/port_tx_if.sv
// port_tx_if: output-port write strobe and data, overflow clear, and the
// transmitter's serial line and status flags, bundled for port_tx.
// master = CPU I/O side, slave = port_tx.
interface port_tx_if #(
  parameter int unsigned DEPTH_LOG2 = 2
);
  logic                  port_wr;
  logic [7:0]            port;
  logic                  ovf_clr;
  logic                  txd;
  logic                  busy;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   fifo_cnt;

  modport master (
    output port_wr, port, ovf_clr,
    input  txd, busy, empty, full, overflow, fifo_cnt
  );

  modport slave (
    input  port_wr, port, ovf_clr,
    output txd, busy, empty, full, overflow, fifo_cnt
  );
endinterface

// File: rtl/port_tx.sv
// port_tx: queues every CPU output-port write in a small FIFO and shifts each byte
// out on txd as an asynchronous frame (start, 8 data bits LSB first, stop).
// Writes are never back-pressured; a write that finds the FIFO full is dropped and
// the sticky overflow flag is raised.
// Optional feature: define PORT_TX_PARITY_EN to insert an even parity bit before
// the stop bit (8E1 frames, 11 bit-times). Without it frames are 8N1 (10 bit-times).
module port_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic     clk,
  input  logic     nrst,
  port_tx_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0]    BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] CntFull  = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef PORT_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  pop;
  logic                  wr_en;
  logic [7:0]            head;

  // Shifter / FSM
  state_e                state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;
`ifdef PORT_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign head = mem_q[rd_ptr_q];

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so a write to a full
  // FIFO is still accepted when the idle shifter takes the head entry.
  always_comb begin
    pop      = (state_q == StIdle) && !empty_q;
    wr_en    = bus.port_wr && (!full_q || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CntFull);
    // A dropped write beats a clear in the same cycle.
    ovf_d = ovf_q;
    if (bus.port_wr && !wr_en) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO storage; no reset needed since only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.port;
    end
  end

  // Frame sequencer next state. txd_d is the level for the cycle after the edge,
  // so each state change also loads the line level of the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
`ifdef PORT_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (baud_q == BaudLast);

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          baud_d  = '0;
          shift_d = head;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef PORT_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef PORT_TX_PARITY_EN
            state_d = StParity;
            txd_d   = par_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            txd_d = shift_q[1];
          end
        end
      end
`ifdef PORT_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset forces txd high at once and flushes the FIFO.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef PORT_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
`ifdef PORT_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overflow = ovf_q;
  assign bus.fifo_cnt = cnt_q;

endmodule

// File: tb/tb_port_tx.sv
// tb_port_tx: directed stimulus for port_tx with a frame-decoding monitor that
// pops expected bytes from a scoreboard queue filled by the stimulus process.
module tb_port_tx;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned DepthLog2 = 2;
`ifdef PORT_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int FrameClks = NBits * ClkDiv;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  port_tx_if #(.DEPTH_LOG2(DepthLog2)) bus ();

  port_tx #(
    .CLK_DIV   (ClkDiv),
    .DEPTH_LOG2(DepthLog2)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  int         starts[$];
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decode frames from txd on the falling clock edge.
  bit         mon_in_frame = 1'b0;
  int         mon_pos      = 0;
  int         mon_sub      = 0;
  bit         mon_held     = 1'b1;
  logic       mon_bits [NBits];
  logic [7:0] mon_data;
  logic [7:0] mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        mon_in_frame = 1'b0;
      end else if (!mon_in_frame) begin
        if (bus.txd == 1'b0) begin
          mon_in_frame = 1'b1;
          mon_pos      = 0;
          mon_sub      = 1;
          mon_bits[0]  = 1'b0;
          mon_held     = 1'b1;
          starts.push_back(cyc);
          check("busy_at_start", bus.busy, 1);
        end
      end else begin
        if (mon_sub == 0) mon_bits[mon_pos] = bus.txd;
        else if (bus.txd !== mon_bits[mon_pos]) mon_held = 1'b0;
        if (mon_sub == ClkDiv - 1) begin
          mon_sub = 0;
          mon_pos++;
        end else begin
          mon_sub++;
        end
        if (mon_pos == NBits) begin
          mon_in_frame = 1'b0;
          for (int i = 0; i < 8; i++) mon_data[i] = mon_bits[i+1];
          check("bit_hold", mon_held, 1);
          check("stop_bit", mon_bits[NBits-1], 1);
`ifdef PORT_TX_PARITY_EN
          check("parity_bit", mon_bits[9], ^mon_data);
`endif
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got %02h, expected no frame", mon_data);
          end else begin
            mon_exp = sb.pop_front();
            check("frame_data", mon_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < bound) begin
      if (sb.size() == 0 && !bus.busy && bus.empty) done = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("drain_in_time", done, 1);
  endtask

  int busy_len;
  int lows;
  int n;

  initial begin
    bus.port_wr = 1'b0;
    bus.port    = 8'h00;
    bus.ovf_clr = 1'b0;
    nrst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", bus.txd, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_fifo_cnt", bus.fifo_cnt, 0);
    nrst = 1'b1;
    tick();

    // Single byte 0xA5: latency and frame length.
    sb.push_back(8'hA5);
    bus.port    = 8'hA5;
    bus.port_wr = 1'b1;
    tick();
    bus.port_wr = 1'b0;
    check("wr_empty_falls", bus.empty, 0);
    check("wr_fifo_cnt", bus.fifo_cnt, 1);
    check("wr_busy_still_low", bus.busy, 0);
    check("wr_txd_still_idle", bus.txd, 1);
    tick();
    check("pop_txd_low", bus.txd, 0);
    check("pop_busy", bus.busy, 1);
    check("pop_empty", bus.empty, 1);
    busy_len = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.busy) break;
      busy_len++;
    end
    check("busy_len", busy_len, FrameClks);
    check("after_txd", bus.txd, 1);
    check("after_empty", bus.empty, 1);
    wait_drain(50);

`ifdef PORT_TX_PARITY_EN
    // Parity build: odd-weight and even-weight bytes.
    sb.push_back(8'h07);
    sb.push_back(8'h03);
    bus.port_wr = 1'b1;
    bus.port    = 8'h07;
    tick();
    bus.port    = 8'h03;
    tick();
    bus.port_wr = 1'b0;
    wait_drain(300);
`endif

    // Back-to-back writes on consecutive cycles.
    starts.delete();
    bus.port_wr = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      bus.port = 8'(b);
      sb.push_back(8'(b));
      tick();
    end
    bus.port_wr = 1'b0;
    wait_drain(400);
    check("b2b_frames", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("b2b_gap0", starts[1] - starts[0], FrameClks + 1);
      check("b2b_gap1", starts[2] - starts[1], FrameClks + 1);
    end
    check("b2b_overflow", bus.overflow, 0);

    // Overflow and pointer wrap: 6 writes with the shifter idle, 6th dropped.
    bus.port_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.port = 8'h10 + 8'(i);
      if (i < 5) sb.push_back(8'h10 + 8'(i));
      tick();
    end
    bus.port_wr = 1'b0;
    check("ovf_full", bus.full, 1);
    check("ovf_fifo_cnt", bus.fifo_cnt, 4);
    check("ovf_flag", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    // Dropped write and clear in the same cycle: set wins.
    bus.ovf_clr = 1'b1;
    bus.port_wr = 1'b1;
    bus.port    = 8'hEE;
    tick();
    bus.ovf_clr = 1'b0;
    bus.port_wr = 1'b0;
    check("ovf_set_wins", bus.overflow, 1);
    check("ovf_cnt_kept", bus.fifo_cnt, 4);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared2", bus.overflow, 0);
    wait_drain(600);

    // Write into a full FIFO in the cycle the idle shifter pops.
    bus.port_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.port = 8'h20 + 8'(i);
      sb.push_back(8'h20 + 8'(i));
      tick();
    end
    bus.port_wr = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check("simul_idle_reached", bus.busy, 0);
    check("simul_pre_cnt", bus.fifo_cnt, 4);
    bus.port    = 8'h25;
    bus.port_wr = 1'b1;
    sb.push_back(8'h25);
    tick();
    bus.port_wr = 1'b0;
    check("simul_cnt", bus.fifo_cnt, 4);
    check("simul_full", bus.full, 1);
    check("simul_overflow", bus.overflow, 0);
    check("simul_busy", bus.busy, 1);
    wait_drain(600);

    // Reset during data bit 3 of 0x52 (bit 3 is 0) with two bytes queued.
    bus.port_wr = 1'b1;
    bus.port    = 8'h52;
    sb.push_back(8'h52);
    tick();
    bus.port    = 8'h53;
    tick();
    bus.port    = 8'h54;
    tick();
    bus.port_wr = 1'b0;
    repeat (16) tick();
    check("pre_rst_txd", bus.txd, 0);
    check("pre_rst_cnt", bus.fifo_cnt, 2);
    nrst = 1'b0;
    #1;
    check("midrst_txd", bus.txd, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cnt", bus.fifo_cnt, 0);
    check("midrst_empty", bus.empty, 1);
    sb.delete();
    tick();
    starts.delete();
    nrst = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.txd !== 1'b1) lows++;
    end
    check("post_rst_txd_lows", lows, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_frames", starts.size(), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/port_tx.md
# port_tx

Serial transmitter for the CPU output port. It sits directly downstream of the I/O stage that latches the 8-bit output port on an OUT instruction. Every port write is queued in a small FIFO and shifted out on `txd` as an asynchronous 8N1 frame, so the CPU never stalls on output. Overflow is flagged rather than back-pressured, because the CPU has no wait path on OUT.

## Interface
- `CLK_DIV`, default 16: clocks per serial bit; legal range 2..65535.
- `DEPTH_LOG2`, default 2: FIFO depth is 2^DEPTH_LOG2 entries (default 4).
- `clk`  in  1: single system clock; all logic uses the rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `port_wr`  in  1: one-clock write strobe, synchronous to `clk`; asserted when the output port is loaded.
- `port`  in  8: port value; sampled on the same edge as `port_wr`.
- `ovf_clr`  in  1: synchronous clear of `overflow`.
- `txd`  out  1: serial line; idle level is 1.
- `busy`  out  1: high while a frame is being shifted (any state except IDLE).
- `empty`  out  1: FIFO holds 0 entries.
- `full`  out  1: FIFO holds 2^DEPTH_LOG2 entries.
- `overflow`  out  1: sticky flag; set when a write is dropped.
- `fifo_cnt`  out  DEPTH_LOG2+1: current FIFO occupancy.

## Operation
- FIFO: circular buffer with read/write pointers and a count.
  - A write is accepted when `port_wr`=1 and either `full`=0 or a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `overflow` is set.
  - A simultaneous write and pop leaves `fifo_cnt` unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- `ovf_clr` clears `overflow`. If `ovf_clr` and a dropped write occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - **IDLE:** `txd`=1. If `empty`=0: pop the head entry into an 8-bit shift register, clear the baud counter, go to START.
  - **START:** `txd`=0 for `CLK_DIV` clocks, then go to DATA with bit index 0.
  - **DATA:** `txd`=shift[0], LSB first. Each bit lasts `CLK_DIV` clocks. Shift right after each bit. After bit 7 go to PARITY if it is compiled in, otherwise STOP.
  - **PARITY:** `txd`=even parity of the byte for `CLK_DIV` clocks, then go to STOP.
  - **STOP:** `txd`=1 for `CLK_DIV` clocks, then go to IDLE.
- Baud counter: runs 0..`CLK_DIV`-1. A bit ends when the counter is at `CLK_DIV`-1. Width is ceil(log2(`CLK_DIV`)).
- Bit index: 3-bit counter, 0..7.
- All outputs are registered; `txd` comes directly from a flop.

## Timing
- Reset values: `txd`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0, `fifo_cnt`=0. FSM=IDLE; pointers, counters and shift register all 0.
- Reset asserted mid-frame: `txd` goes to 1 immediately (asynchronously). The FIFO is flushed and the frame is lost.
- Latency, `port_wr` at edge N into an empty FIFO with FSM idle:
  - `empty` falls after edge N.
  - Pop occurs at edge N+1.
  - `txd` falls and `busy` rises after edge N+1.
- Frame length: 10×`CLK_DIV` clocks (11×`CLK_DIV` with parity).
- Back-to-back frames: one IDLE clock between the end of STOP and the next START. Period is 10×`CLK_DIV`+1 clocks.
- `port_wr` held high for k cycles produces k write attempts; the strobe is not edge-detected.

## Configuration
- `PORT_TX_PARITY_EN`
  - Defined: the PARITY state is present and frames are 8E1, 11 bit-times each.
  - Undefined: the PARITY state and its logic are absent and frames are 8N1, 10 bit-times each.
  - FIFO and overflow behaviour are identical in both builds.

## Test plan
- **Single byte:** `CLK_DIV`=4, write 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; `busy` high for 40 clocks; `empty`=1 afterwards.
- **Back-to-back:** write 0x01, 0x02, 0x03 on consecutive cycles → three frames in order, each 41 clocks apart, `overflow`=0.
- **Overflow and wrap:** DEPTH 4, writes on cycles 0..5 with the FSM idle → 5 bytes accepted (1 in the shifter, 4 in the FIFO), 6th dropped. `full`=1, `fifo_cnt`=4, `overflow`=1. After `ovf_clr`, `overflow`=0. All 5 bytes are transmitted in order across the pointer wrap.
- **Simultaneous write and pop when full:** FIFO full and the FSM reaching IDLE with a `port_wr` in the same cycle → write accepted, `fifo_cnt` stays 4, `overflow` stays 0.
- **Parity build:** with `PORT_TX_PARITY_EN` defined, write 0x07 → parity bit 1 inserted before the stop bit; write 0x03 → parity bit 0; frames are 44 clocks at `CLK_DIV`=4.
- **Reset mid-frame:** drop `nrst` during DATA bit 3 → `txd`=1, `busy`=0, `fifo_cnt`=0 immediately. No partial frame resumes after release.
